// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared states and constants for the serial frame receiver
package frame_pkg;
  localparam int MAX_BYTES = 15;
  localparam int CRC_W     = 8;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SIZE    = 3'd1,
    ST_DATA    = 3'd2,
    ST_CRC     = 3'd3,
    ST_STOP    = 3'd4,
    ST_DELIVER = 3'd5
  } state_t;
endpackage

// File: rtl/frame_rx_ctrl.sv
// rtl/frame_rx_ctrl.sv - framing FSM for voted serial bits, drives an external CRC engine
module frame_rx_ctrl #(
  parameter int MAX_BYTES = frame_pkg::MAX_BYTES,
  parameter int CRC_W     = frame_pkg::CRC_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bit_valid,
  input  logic                   bit_val,
  input  logic                   bit_noise,
  output logic                   crc_clr,
  output logic                   crc_en,
  output logic                   crc_bit,
  input  logic [CRC_W-1:0]       crc_val,
  output logic                   frm_valid,
  input  logic                   frm_ready,
  output logic [3:0]             frm_size,
  output logic [8*MAX_BYTES-1:0] frm_data,
  output logic                   err_crc,
  output logic                   err_frame,
  output logic                   err_noise,
  output logic                   busy
);
  import frame_pkg::*;

  localparam int CRC_CW = (CRC_W > 1) ? $clog2(CRC_W) : 1;

  state_t                   state_q, state_d;
  logic [3:0]               size_q, size_d;
  logic [8*MAX_BYTES-1:0]   data_q, data_d;
  logic [6:0]               byte_sr_q, byte_sr_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [3:0]               byte_cnt_q, byte_cnt_d;
  logic [CRC_CW-1:0]        crc_cnt_q, crc_cnt_d;
  logic [CRC_W-1:0]         crc_rx_q, crc_rx_d;
  logic                     err_crc_q, err_crc_d;
  logic                     err_frame_q, err_frame_d;
  logic                     err_noise_q, err_noise_d;
  logic                     crc_en_q, crc_en_d;
  logic                     crc_bit_q, crc_bit_d;
  logic                     crc_clr_q, crc_clr_d;
  logic                     frm_valid_q, frm_valid_d;

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    data_d      = data_q;
    byte_sr_d   = byte_sr_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    crc_cnt_d   = crc_cnt_q;
    crc_rx_d    = crc_rx_q;
    err_crc_d   = err_crc_q;
    err_frame_d = err_frame_q;
    err_noise_d = err_noise_q;
    crc_en_d    = 1'b0;
    crc_bit_d   = crc_bit_q;
    frm_valid_d = frm_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bit_valid && (bit_val == START_BIT) && !bit_noise) begin
          state_d     = ST_SIZE;
          size_d      = 4'd0;
          data_d      = '0;
          bit_cnt_d   = 3'd0;
          byte_cnt_d  = 4'd0;
          crc_cnt_d   = '0;
          err_crc_d   = 1'b0;
          err_frame_d = 1'b0;
          err_noise_d = 1'b0;
        end
      end
      ST_SIZE: begin
        if (bit_valid) begin
          size_d    = {size_q[2:0], bit_val};
          crc_en_d  = 1'b1;
          crc_bit_d = bit_val;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd3) begin
            bit_cnt_d = 3'd0;
            if (size_d == 4'd0) begin
              err_frame_d = 1'b1;
              state_d     = ST_CRC;
            end else begin
              if (int'(size_d) > MAX_BYTES) err_frame_d = 1'b1;
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (bit_valid) begin
          crc_en_d  = 1'b1;
          crc_bit_d = bit_val;
          byte_sr_d = {byte_sr_q[5:0], bit_val};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // Oversized frames still run to the end; bytes past MAX_BYTES are dropped here.
            for (int k = 0; k < MAX_BYTES; k++) begin
              if (byte_cnt_q == 4'(k)) data_d[8*MAX_BYTES-1-8*k -: 8] = {byte_sr_q, bit_val};
            end
            byte_cnt_d = byte_cnt_q + 4'd1;
            if (byte_cnt_q == size_q - 4'd1) state_d = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        if (bit_valid) begin
          crc_rx_d  = (crc_rx_q << 1) | CRC_W'(bit_val);
          crc_cnt_d = crc_cnt_q + CRC_CW'(1);
          if (crc_cnt_q == CRC_CW'(CRC_W - 1)) begin
            err_crc_d = (crc_rx_d != crc_val);
            state_d   = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (bit_valid) begin
          if (bit_val != STOP_BIT) err_frame_d = 1'b1;
          frm_valid_d = 1'b1;
          state_d     = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (frm_ready) begin
          frm_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bit_valid && bit_noise && (state_q inside {ST_SIZE, ST_DATA, ST_CRC, ST_STOP}))
      err_noise_d = 1'b1;

    crc_clr_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      size_q      <= 4'd0;
      data_q      <= '0;
      byte_sr_q   <= 7'd0;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 4'd0;
      crc_cnt_q   <= '0;
      crc_rx_q    <= '0;
      err_crc_q   <= 1'b0;
      err_frame_q <= 1'b0;
      err_noise_q <= 1'b0;
      crc_en_q    <= 1'b0;
      crc_bit_q   <= 1'b0;
      crc_clr_q   <= 1'b1;
      frm_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      data_q      <= data_d;
      byte_sr_q   <= byte_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_cnt_q   <= crc_cnt_d;
      crc_rx_q    <= crc_rx_d;
      err_crc_q   <= err_crc_d;
      err_frame_q <= err_frame_d;
      err_noise_q <= err_noise_d;
      crc_en_q    <= crc_en_d;
      crc_bit_q   <= crc_bit_d;
      crc_clr_q   <= crc_clr_d;
      frm_valid_q <= frm_valid_d;
    end
  end

  assign crc_clr   = crc_clr_q;
  assign crc_en    = crc_en_q;
  assign crc_bit   = crc_bit_q;
  assign frm_valid = frm_valid_q;
  assign frm_size  = size_q;
  assign frm_data  = data_q;
  assign err_crc   = err_crc_q;
  assign err_frame = err_frame_q;
  assign err_noise = err_noise_q;
  assign busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_frame_rx_ctrl.sv
// tb/tb_frame_rx_ctrl.sv - directed and random frames against a bit-list reference model
module tb_frame_rx_ctrl;
  localparam int MAXB = 15;
  localparam int CW   = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              bit_valid = 1'b0, bit_val = 1'b0, bit_noise = 1'b0;
  logic              frm_ready = 1'b0;
  logic              crc_clr, crc_en, crc_bit;
  logic [CW-1:0]     crc_eng;
  logic              frm_valid;
  logic [3:0]        frm_size;
  logic [8*MAXB-1:0] frm_data;
  logic              err_crc, err_frame, err_noise, busy;

  frame_rx_ctrl #(.MAX_BYTES(MAXB), .CRC_W(CW)) dut (
    .clk(clk), .reset(reset),
    .bit_valid(bit_valid), .bit_val(bit_val), .bit_noise(bit_noise),
    .crc_clr(crc_clr), .crc_en(crc_en), .crc_bit(crc_bit), .crc_val(crc_eng),
    .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_size(frm_size), .frm_data(frm_data),
    .err_crc(err_crc), .err_frame(err_frame), .err_noise(err_noise), .busy(busy)
  );

  always #5 clk = ~clk;

  // CRC-8 (poly 0x07), MSB-first serial update
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // Stand-in for the external CRC engine
  always @(posedge clk) begin
    if (crc_clr) crc_eng <= 8'h00;
    else if (crc_en) crc_eng <= crc_step(crc_eng, crc_bit);
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic              bits[$];
  logic [7:0]        pay[16];
  logic [3:0]        e_size;
  logic [8*MAXB-1:0] e_data;
  logic              e_crc, e_frame, e_noise;
  int                noise_at;

  task automatic build(input logic [3:0] sz, input int flip, input logic stop, input int nidx);
    logic [7:0] c;
    c = 8'h00;
    bits.delete();
    bits.push_back(1'b1);
    for (int i = 3; i >= 0; i--) begin
      bits.push_back(sz[i]);
      c = crc_step(c, sz[i]);
    end
    for (int k = 0; k < int'(sz); k++)
      for (int i = 7; i >= 0; i--) begin
        bits.push_back(pay[k][i]);
        c = crc_step(c, pay[k][i]);
      end
    for (int j = 0; j < 8; j++) bits.push_back(c[7-j] ^ (j == flip));
    bits.push_back(stop);
    e_size = sz;
    e_data = '0;
    for (int k = 0; k < int'(sz) && k < MAXB; k++) e_data[8*MAXB-1-8*k -: 8] = pay[k];
    e_frame  = (sz == 4'd0) || (int'(sz) > MAXB) || (stop != 1'b0);
    e_crc    = (flip >= 0);
    e_noise  = (nidx > 0);
    noise_at = nidx;
  endtask

  task automatic strobe(input logic v, input logic n);
    @(negedge clk);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bit_valid = 1'b1;
    bit_val   = v;
    bit_noise = n;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_noise = 1'b0;
  endtask

  task automatic send(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      strobe(bits[i], i == noise_at);
      if (i == 0) chk({tag, "_busy_start"}, busy, 1);
    end
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_valid"}, frm_valid, 1);
    chk({tag, "_size"}, frm_size, e_size);
    chk({tag, "_data"}, frm_data, e_data);
    chk({tag, "_err_crc"}, err_crc, e_crc);
    chk({tag, "_err_frame"}, err_frame, e_frame);
    chk({tag, "_err_noise"}, err_noise, e_noise);
    chk({tag, "_busy"}, busy, 1);
  endtask

  task automatic run(input logic [3:0] sz, input int flip, input logic stop, input int nidx,
                     input logic early, input int hold, input string tag);
    build(sz, flip, stop, nidx);
    frm_ready = early;
    send(bits.size(), tag);
    check_out(tag);
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk({tag, "_hold_valid"}, frm_valid, 1);
        chk({tag, "_hold_data"}, frm_data, e_data);
      end
      frm_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_done_valid"}, frm_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
    frm_ready = 1'b0;
  endtask

  int   r_sz, r_flip, r_nidx;
  logic r_stop, r_early;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", frm_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_crc_en", crc_en, 0);
    chk("rst_crc_bit", crc_bit, 0);
    chk("rst_crc_clr", crc_clr, 1);
    chk("rst_size", frm_size, 0);
    chk("rst_data", frm_data, 0);
    chk("rst_errs", {err_crc, err_frame, err_noise}, 0);
    reset = 1'b0;

    pay[0] = 8'hA5;
    pay[1] = 8'h3C;
    run(4'd2, -1, 1'b0, -1, 1'b0, 2, "basic");
    run(4'd2, 5, 1'b0, -1, 1'b0, 0, "crcflip");
    run(4'd2, -1, 1'b1, -1, 1'b1, 0, "stop1");
    run(4'd0, -1, 1'b0, -1, 1'b0, 1, "size0");

    // Consumer stalls while more strobes arrive
    build(4'd2, -1, 1'b0, -1);
    send(bits.size(), "stall");
    check_out("stall");
    for (int c = 0; c < 10; c++) begin
      bit_valid = (c % 2 == 0);
      bit_val   = 1'b1;
      @(negedge clk);
      chk("stall_valid", frm_valid, 1);
      chk("stall_data", frm_data, e_data);
      chk("stall_flags", {frm_size, err_crc, err_frame, err_noise}, {e_size, e_crc, e_frame, e_noise});
    end
    bit_valid = 1'b0;
    frm_ready = 1'b1;
    @(negedge clk);
    chk("stall_done_valid", frm_valid, 0);
    chk("stall_done_busy", busy, 0);
    frm_ready = 1'b0;
    @(negedge clk);
    chk("stall_no_new_frame", busy, 0);

    // Asynchronous reset after the third data bit
    build(4'd2, -1, 1'b0, -1);
    send(8, "midrst");
    chk("midrst_busy_before", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", frm_valid, 0);
    chk("midrst_crc_clr", crc_clr, 1);
    chk("midrst_crc_en", crc_en, 0);
    chk("midrst_size", frm_size, 0);
    chk("midrst_data", frm_data, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) pay[k] = 8'($urandom);
    run(4'd3, -1, 1'b0, -1, 1'b0, 0, "after_rst");

    run(4'd3, -1, 1'b0, 10, 1'b0, 0, "noise_d5");

    strobe(1'b1, 1'b1);
    chk("noisy_start_busy", busy, 0);
    strobe(1'b0, 1'b0);
    chk("zero_start_busy", busy, 0);

    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 16; k++) pay[k] = 8'($urandom);
      r_sz    = $urandom_range(0, 15);
      r_flip  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      r_stop  = ($urandom_range(0, 3) == 0);
      r_nidx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 13 + 8 * r_sz)) : -1;
      r_early = ($urandom_range(0, 2) == 0);
      run(4'(r_sz), r_flip, r_stop, r_nidx, r_early, $urandom_range(0, 3), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_rx_ctrl.md
FRAME_RX_CTRL -- requirements
Module: frame_rx_ctrl

Interface
REQ-001: Parameters, one per line (name, default, meaning):
- MAX_BYTES, 15, maximum payload bytes.
- CRC_W, 8, CRC width.
REQ-002: Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on posedge clk.
- reset, in, 1, asynchronous, active-high reset.
- bit_valid, in, 1, one-cycle strobe: one majority-voted serial bit is available.
- bit_val, in, 1, voted bit value; qualified by bit_valid.
- bit_noise, in, 1, noise detected on this bit; qualified by bit_valid.
- crc_clr, out, 1, clears the external CRC engine.
- crc_en, out, 1, one-cycle CRC update strobe.
- crc_bit, out, 1, bit fed to the CRC engine.
- crc_val, in, CRC_W, CRC engine register; updates the cycle after crc_en.
- frm_valid, out, 1, frame available.
- frm_ready, in, 1, consumer accepts the frame.
- frm_size, out, 4, received payload byte count.
- frm_data, out, 8*MAX_BYTES, payload; byte k at bits [8*MAX_BYTES-1-8k -: 8].
- err_crc, out, 1, CRC mismatch; valid with frm_valid.
- err_frame, out, 1, bad stop bit or size 0; valid with frm_valid.
- err_noise, out, 1, any noisy bit in the frame; valid with frm_valid.
- busy, out, 1, high in every state except IDLE.

Function
REQ-003: FSM states: IDLE, SIZE, DATA, CRC, STOP, DELIVER.
REQ-004: Only cycles with bit_valid=1 advance SIZE/DATA/CRC/STOP; other cycles hold state.
REQ-005: IDLE:
- crc_clr=1.
- On bit_valid & bit_val=1 & ~bit_noise (start bit): clear frm_data, errors and counters; go to SIZE.
- Start bits with noise, or with bit_val=0, are ignored.
REQ-006: SIZE:
- 4 bits, MSB first, shift into frm_size.
- Each bit: crc_en=1 and crc_bit=bit_val in the same cycle.
- After the 4th bit: go to DATA if size is nonzero.
- If size is 0: set err_frame and go to CRC.
REQ-007: DATA:
- frm_size*8 bits, MSB first per byte, byte order k=0 upward.
- Each bit pulses crc_en with crc_bit=bit_val.
- After the last bit of byte frm_size-1, go to CRC.
REQ-008: If frm_size > MAX_BYTES, set err_frame, store only MAX_BYTES bytes, and still consume and CRC all bits.
REQ-009: CRC:
- CRC_W bits, MSB first, into a shift register; crc_en stays 0.
- On the final CRC bit: err_crc = (received != crc_val); go to STOP.
REQ-010: STOP:
- One bit; bit_val=1 sets err_frame.
- Go to DELIVER.
REQ-011: DELIVER:
- frm_valid=1 the cycle after the stop-bit strobe.
- frm_valid, frm_size, frm_data and the error flags are held stable until frm_ready=1.
- Transfer occurs on the cycle with frm_valid & frm_ready; the next cycle is IDLE with frm_valid=0.
- frm_ready already high when frm_valid rises completes the transfer in that first cycle.
REQ-012: bit_valid in DELIVER is ignored and does not start a new frame.
REQ-013: bit_noise=1 on any strobe in SIZE..STOP sets err_noise, sticky until the next start bit; reception continues.
REQ-014: Bit counter is 3 bits and byte counter is 4 bits; no wrap occurs within legal sizes.
REQ-015: crc_en, crc_clr and frm_valid are registered outputs.

Reset
REQ-016: reset=1 forces IDLE asynchronously, including mid-frame.
REQ-017: Reset values:
- frm_valid=0, busy=0, crc_en=0, crc_bit=0.
- frm_size=0, frm_data=0, all error flags 0.
- crc_clr=1.
REQ-018: After reset is released, the first strobe is evaluated as a start-bit candidate.

Structure
REQ-019: Shared package frame_pkg holds:
- the state enum;
- MAX_BYTES, CRC_W;
- START_BIT=1, STOP_BIT=0.
REQ-020: No sub-module; the existing crc engine stays external and is driven through crc_clr, crc_en and crc_bit.

Verification
REQ-021: Bit stream 1, 0010, 0xA5, 0x3C, correct CRC, 0 -> frm_valid, frm_size=2, bytes A5 3C, all error flags 0.
REQ-022: Same frame with one CRC bit flipped -> err_crc=1, data still A5 3C.
REQ-023: Stop bit=1 -> err_frame=1; size field 0000 -> err_frame=1 and CRC compared over the 4 size bits only.
REQ-024: frm_ready low for 10 cycles, with 5 extra strobes meanwhile -> outputs held stable, no new frame started, IDLE one cycle after ready.
REQ-025: reset asserted after the 3rd DATA bit -> immediate IDLE with reset values; the next full frame is received correctly.
REQ-026: bit_noise on data bit 5 -> err_noise=1 and frame delivered; noisy start bit -> ignored, busy stays 0.
